// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and load/store.
// MEM has priority; a starvation counter forces an IF grant after STARVE_LIMIT MEM grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  input  logic                    if_flush,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_ready,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_wmask,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_ready,
  output logic                    ram_en,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic                    stall_if,
  output logic                    stall_mem
);

  localparam int unsigned MaskW = DATA_WIDTH / 8;
  localparam int unsigned LatW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned StW   = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;
  typedef enum logic {OwnIf, OwnMem} owner_e;

  state_e                  state_q, state_d;
  owner_e                  owner_q, owner_d;
  logic [LatW-1:0]         lat_cnt_q, lat_cnt_d;
  logic [StW-1:0]          starve_cnt_q, starve_cnt_d;
  logic                    cancel_q, cancel_d;
  logic                    if_ready_q, if_ready_d;
  logic                    mem_ready_q, mem_ready_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]   mem_rdata_q, mem_rdata_d;
  logic                    ram_en_q, ram_en_d;
  logic [MaskW-1:0]        ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;

  logic grant_mem, grant_if, flush_hit, done_entry;

  assign grant_mem = mem_req && !(if_req && (starve_cnt_q == StW'(STARVE_LIMIT)));
  assign grant_if  = if_req && !grant_mem;
  assign flush_hit = if_flush && (owner_q == OwnIf) &&
                     ((state_q == StIssue) || (state_q == StWait));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    cancel_d     = cancel_q | flush_hit;
    ram_en_d     = 1'b0;
    ram_we_d     = '0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    done_entry   = 1'b0;
    // RAM data is valid during the ready cycle; latch it as the ready pulse ends.
    if_rdata_d   = if_ready_q  ? ram_rdata : if_rdata_q;
    mem_rdata_d  = mem_ready_q ? ram_rdata : mem_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_mem || grant_if) begin
          state_d     = StIssue;
          owner_d     = grant_mem ? OwnMem : OwnIf;
          ram_en_d    = 1'b1;
          ram_addr_d  = grant_mem ? mem_addr : if_addr;
          ram_wdata_d = grant_mem ? mem_wdata : '0;
          ram_we_d    = (grant_mem && mem_we) ? mem_wmask : '0;
          if (grant_mem && if_req) begin
            if (starve_cnt_q != StW'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + StW'(1);
          end else begin
            starve_cnt_d = '0;
          end
        end
      end
      StIssue: begin
        lat_cnt_d = LatW'(MEM_LATENCY - 1);
        if (MEM_LATENCY > 1) begin
          state_d = StWait;
        end else begin
          state_d    = StDone;
          done_entry = 1'b1;
        end
      end
      StWait: begin
        lat_cnt_d = lat_cnt_q - LatW'(1);
        if (lat_cnt_q == LatW'(1)) begin
          state_d    = StDone;
          done_entry = 1'b1;
        end
      end
      StDone: begin
        state_d  = StIdle;
        cancel_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    if_ready_d  = done_entry && (owner_q == OwnIf) && !(cancel_q || flush_hit);
    mem_ready_d = done_entry && (owner_q == OwnMem);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnIf;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      cancel_q     <= 1'b0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      cancel_q     <= cancel_d;
      if_ready_q   <= if_ready_d;
      mem_ready_q  <= mem_ready_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;
  assign if_rdata  = if_ready_q  ? ram_rdata : if_rdata_q;
  assign mem_rdata = mem_ready_q ? ram_rdata : mem_rdata_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = mem_req & ~mem_ready_q;

  // Held requests must not change while their access is on the RAM.
  mem_hold_a: assert property (@(posedge clk) disable iff (rst)
    ((state_q == StIssue || state_q == StWait) && owner_q == OwnMem) |->
      (mem_req && $stable(mem_addr) && $stable(mem_we) && $stable(mem_wdata) && $stable(mem_wmask)));

  if_hold_a: assert property (@(posedge clk) disable iff (rst)
    ((state_q == StIssue || state_q == StWait) && owner_q == OwnIf && !cancel_q && !if_flush) |->
      $stable(if_addr));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, load/fetch priority, store, flush, starvation.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
  logic [3:0]  mem_wmask;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_ready, mem_ready, ram_en, stall_if, stall_mem;
  logic [3:0]  ram_we;
  logic [31:0] p1, p2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .MEM_LATENCY (2),
    .STARVE_LIMIT(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .stall_if (stall_if),
    .stall_mem(stall_mem)
  );

  function automatic logic [31:0] ram_model(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Two-stage read pipe: data valid two cycles after the ram_en cycle.
  always @(posedge clk) begin
    p1 <= ram_en ? ram_model(ram_addr) : 32'hBAD0_BAD0;
    p2 <= p1;
  end
  assign ram_rdata = p2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] grants [4];
    logic [31:0] exp_g [4];
    int          ng;
    logic        seen;

    rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
    repeat (2) cyc();
    chk("por_ram_en", {31'd0, ram_en}, 32'd0);
    chk("por_if_ready", {31'd0, if_ready}, 32'd0);
    rst = 1'b0;
    cyc();

    // Reset asserted in the middle of WAIT.
    if_req = 1'b1; if_addr = 32'h100;
    cyc();
    chk("t1_issue_en", {31'd0, ram_en}, 32'd1);
    cyc();
    rst = 1'b1; if_req = 1'b0;
    #1;
    chk("t1_rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("t1_rst_ram_addr", ram_addr, 32'd0);
    chk("t1_rst_ram_we", {28'd0, ram_we}, 32'd0);
    chk("t1_rst_if_rdata", if_rdata, 32'd0);
    repeat (3) cyc();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (if_ready || mem_ready || ram_en) seen = 1'b1;
    end
    chk("t1_no_pulse_after_rst", {31'd0, seen}, 32'd0);

    // Single fetch, latency 2.
    if_req = 1'b1; if_addr = 32'h100;
    #1 chk("t2_stall_c0", {31'd0, stall_if}, 32'd1);
    cyc();
    chk("t2_en_c1", {31'd0, ram_en}, 32'd1);
    chk("t2_addr_c1", ram_addr, 32'h100);
    chk("t2_stall_c1", {31'd0, stall_if}, 32'd1);
    cyc();
    chk("t2_en_c2", {31'd0, ram_en}, 32'd0);
    chk("t2_stall_c2", {31'd0, stall_if}, 32'd1);
    cyc();
    chk("t2_ready_c3", {31'd0, if_ready}, 32'd1);
    chk("t2_rdata_c3", if_rdata, 32'h0050_0093);
    chk("t2_stall_c3", {31'd0, stall_if}, 32'd0);
    if_req = 1'b0;
    cyc();
    chk("t2_ready_c4", {31'd0, if_ready}, 32'd0);
    chk("t2_rdata_hold", if_rdata, 32'h0050_0093);

    // Simultaneous fetch and load: MEM first.
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000;
    cyc();
    chk("t3_mem_issue_addr", ram_addr, 32'h2000);
    chk("t3_mem_issue_en", {31'd0, ram_en}, 32'd1);
    cyc();
    cyc();
    chk("t3_mem_ready_c3", {31'd0, mem_ready}, 32'd1);
    chk("t3_mem_rdata_c3", mem_rdata, 32'hA5A5_2000);
    chk("t3_if_ready_c3", {31'd0, if_ready}, 32'd0);
    mem_req = 1'b0;
    cyc();
    chk("t3_mem_ready_c4", {31'd0, mem_ready}, 32'd0);
    chk("t3_en_c4", {31'd0, ram_en}, 32'd0);
    cyc();
    chk("t3_if_issue_en_c5", {31'd0, ram_en}, 32'd1);
    chk("t3_if_issue_addr_c5", ram_addr, 32'h100);
    cyc();
    cyc();
    chk("t3_if_ready_c7", {31'd0, if_ready}, 32'd1);
    chk("t3_if_rdata_c7", if_rdata, 32'h0050_0093);
    if_req = 1'b0;
    cyc();

    // Byte-masked store.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2004;
    mem_wdata = 32'hDEAD_BEEF; mem_wmask = 4'b0011;
    cyc();
    chk("t4_en_c1", {31'd0, ram_en}, 32'd1);
    chk("t4_we_c1", {28'd0, ram_we}, 32'h3);
    chk("t4_wdata_c1", ram_wdata, 32'hDEAD_BEEF);
    chk("t4_addr_c1", ram_addr, 32'h2004);
    cyc();
    chk("t4_we_c2", {28'd0, ram_we}, 32'd0);
    chk("t4_stall_mem_c2", {31'd0, stall_mem}, 32'd1);
    chk("t4_ready_c2", {31'd0, mem_ready}, 32'd0);
    cyc();
    chk("t4_ready_c3", {31'd0, mem_ready}, 32'd1);
    mem_req = 1'b0; mem_we = 1'b0; mem_wmask = '0;
    cyc();
    chk("t4_ready_c4", {31'd0, mem_ready}, 32'd0);

    // Flush during WAIT, then redirected fetch.
    if_req = 1'b1; if_addr = 32'h180;
    cyc();
    cyc();
    if_flush = 1'b1; if_addr = 32'h200;
    cyc();
    chk("t6_cancel_ready_c3", {31'd0, if_ready}, 32'd0);
    chk("t6_cancel_rdata_c3", if_rdata, 32'h0050_0093);
    if_flush = 1'b0;
    cyc();
    chk("t6_rdata_kept_c4", if_rdata, 32'h0050_0093);
    cyc();
    chk("t6_issue_en_c5", {31'd0, ram_en}, 32'd1);
    chk("t6_issue_addr_c5", ram_addr, 32'h200);
    cyc();
    cyc();
    chk("t6_ready_c7", {31'd0, if_ready}, 32'd1);
    chk("t6_rdata_c7", if_rdata, 32'hA5A5_0200);
    if_req = 1'b0;
    cyc();

    // Starvation with limit 2: MEM, MEM, IF, MEM.
    exp_g[0] = 32'h3000; exp_g[1] = 32'h3000; exp_g[2] = 32'h400; exp_g[3] = 32'h3000;
    for (int i = 0; i < 4; i++) grants[i] = '0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3000;
    if_req = 1'b1; if_addr = 32'h400;
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      cyc();
      if (ram_en) begin
        grants[ng] = ram_addr;
        ng++;
      end
      if (if_ready) if_req = 1'b0;
    end
    chk("t5_grant_count", ng, 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_grant%0d", i), grants[i], exp_g[i]);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc();
      if (mem_ready) seen = 1'b1;
    end
    chk("t5_last_mem_ready", {31'd0, seen}, 32'd1);
    mem_req = 1'b0; if_req = 1'b0;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
